rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning write-data width.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width (32 registers).
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 (ALU writeback) has a write.
- r0_addr  in  AW  requester 0 destination register.
- r0_data  in  DW  requester 0 write data.
- r0_ready  out  1  requester 0 grant; transfer when r0_valid&&r0_ready.
- r1_valid, r1_addr, r1_data, r1_ready  as r0_*  requester 1 (load/multicycle writeback).
- iss_valid  in  1  an instruction writing iss_addr is issued this cycle.
- iss_addr  in  AW  destination of the issued instruction.
- chk_a1, chk_a2  in  AW  source registers being read this cycle.
- stall  out  1  a source register has an uncommitted write.
- RFWr  out  1  register-file write enable.
- RegAdd  out  AW  register-file write address.
- RegWriData  out  DW  register-file write data.
- idle  out  1  no pending writes and RFWr low.
- sb_ovf  out  1  sticky scoreboard overflow flag.

Function
REQ-004 Grants SHALL be combinational from valids and the round-robin pointer rr; at most one of r0_ready/r1_ready is high per cycle.
REQ-005 Only r0_valid: r0_ready=1. Only r1_valid: r1_ready=1. Neither valid: both readies 0.
REQ-006 Both valid: grant requester rr (0 or 1); on that transfer rr SHALL toggle to the other requester.
REQ-007 A single-requester transfer SHALL set rr to the non-granted requester.
REQ-008 A transfer in cycle N SHALL drive RFWr=1, RegAdd=addr and RegWriData=data in cycle N+1 (one-cycle registered latency).
REQ-009 RFWr SHALL be 0 in any cycle following a cycle without a transfer; RegAdd and RegWriData SHALL hold their last values.
REQ-010 A transfer with addr 0 SHALL be accepted but SHALL produce RFWr=0 and no scoreboard change.
REQ-011 A 2-bit pending counter cnt[r] SHALL be kept for each register r=1..31.
- increments at the edge where iss_valid=1 and iss_addr=r.
- decrements at the edge where RFWr=1 and RegAdd=r (the commit edge).
- both events in the same cycle: unchanged.
REQ-012 iss_valid with iss_addr=0 SHALL be ignored.
REQ-013 An increment with cnt[r]=3 (no simultaneous decrement) SHALL leave cnt[r]=3 and set sb_ovf=1 until reset.
REQ-014 A decrement with cnt[r]=0 SHALL leave cnt[r]=0 (requester wrote an unissued register; no flag).
REQ-015 stall SHALL be combinational: (chk_a1!=0 && cnt[chk_a1]!=0) || (chk_a2!=0 && cnt[chk_a2]!=0).
REQ-016 stall SHALL NOT be affected by iss_valid in the same cycle; a new pending write is visible from the next cycle.
REQ-017 idle SHALL be 1 when all cnt are 0 and RFWr=0.
REQ-018 Arbitration SHALL NOT depend on scoreboard state; the block SHALL never drop an accepted transfer.

Reset
REQ-019 While rst=1, asynchronously: RFWr=0, RegAdd=0, RegWriData=0, rr=0, all cnt=0, sb_ovf=0.
REQ-020 While rst=1, r0_ready and r1_ready SHALL be 0 and stall SHALL be 0.
REQ-021 Reset mid-operation SHALL discard the output register and all pending counts; the first post-reset grant on contention goes to requester 0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, then r0 write (r3, 0x11) alone -> r0_ready=1; next cycle RFWr=1, RegAdd=3, RegWriData=0x00000011.
- Both valid for 4 cycles after reset -> grants r0, r1, r0, r1; RFWr=1 in 4 consecutive cycles with matching address/data.
- iss r5, then chk_a1=5 -> stall=1; r1 writes r5 -> stall stays 1 through the RFWr cycle and drops the cycle after.
- Four iss to r7, no writes -> cnt[7]=3, sb_ovf=1; iss r7 and commit r7 in the same cycle -> cnt unchanged.
- Write to r0 with data 0xFFFFFFFF -> accepted; RFWr remains 0; idle stays 1.
- rst pulse mid-burst with cnt[9]=2 and RFWr=1 -> immediately RFWr=0, stall=0 for chk_a1=9, idle=1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter for two register-file writeback requesters,
// with a per-register pending-write scoreboard that drives stall.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_data,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_data,
    output logic          r1_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] chk_a1,
    input  logic [AW-1:0] chk_a2,
    output logic          stall,
    output logic          RFWr,
    output logic [AW-1:0] RegAdd,
    output logic [DW-1:0] RegWriData,
    output logic          idle,
    output logic          sb_ovf
);
    localparam int NR = 1 << AW;
    logic                 rr_q, rr_d;
    logic                 rfwr_q;
    logic [AW-1:0]        regadd_q;
    logic [DW-1:0]        wdata_q;
    logic [NR-1:0][1:0]   cnt_q, cnt_d;
    logic [NR-1:0]        inc, dec;
    logic                 ovf_q, ovf_d;
    logic                 xfer;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_data;
    assign r0_ready = !rst && r0_valid && !(r1_valid && rr_q);
    assign r1_ready = !rst && r1_valid && !(r0_valid && !rr_q);
    assign xfer     = r0_ready || r1_ready;
    assign w_addr   = r1_ready ? r1_addr : r0_addr;
    assign w_data   = r1_ready ? r1_data : r0_data;
    assign rr_d     = r0_ready ? 1'b1 : r1_ready ? 1'b0 : rr_q;
    // Register 0 is never tracked, so cnt_q[0] stays zero and needs no guard in the lookups.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        inc   = '0;
        dec   = '0;
        for (int r = 1; r < NR; r++) begin
            inc[r]   = iss_valid && iss_addr == AW'(r);
            dec[r]   = rfwr_q && regadd_q == AW'(r);
            cnt_d[r] = (inc[r] && !dec[r]) ? ((&cnt_q[r]) ? 2'd3 : cnt_q[r] + 2'd1)
                     : (dec[r] && !inc[r]) ? ((|cnt_q[r]) ? cnt_q[r] - 2'd1 : 2'd0)
                     : cnt_q[r];
            ovf_d    = ovf_d || (inc[r] && !dec[r] && (&cnt_q[r]));
        end
    end
    assign stall = !rst && ((chk_a1 != '0 && cnt_q[chk_a1] != 2'd0) ||
                            (chk_a2 != '0 && cnt_q[chk_a2] != 2'd0));
    assign idle       = (cnt_q == '0) && !rfwr_q;
    assign RFWr       = rfwr_q;
    assign RegAdd     = regadd_q;
    assign RegWriData = wdata_q;
    assign sb_ovf     = ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q     <= 1'b0;
            rfwr_q   <= 1'b0;
            regadd_q <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            rfwr_q <= xfer && w_addr != '0;
            if (xfer) begin
                regadd_q <= w_addr;
                wdata_q  <= w_data;
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule
